// File: rtl/usb_ep_fifo.sv
// usb_ep_fifo -- single-clock byte FIFO for a USB endpoint.
//
// The fabric side writes WWIDTH-bit words with a contiguous lane mask. Lanes
// are scattered into NB = WWIDTH/8 interleaved byte banks, so a beat may start
// at any byte alignment. The USB side drains an 8-bit first-word-fall-through
// stream. The stream is built from two parts: the bank read issue (prefetch)
// and the banks' registered read data (output register).
//
// Optional feature: define USB_EP_FIFO_LAST_EN to add wr_last/rd_last. With it
// defined, each bank stores a 9th bit that tags the final byte of a packet.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   wr_data[WWIDTH]      write word, lane i = bits [8i+7:8i]
//   wr_mask[NB]          lane enables, contiguous from lane 0
//   wr_valid / wr_ready  write handshake (wr_ready: room for a full word)
//   wr_last              (LAST_EN) tag the highest enabled lane
//   rd_data[8]           head byte
//   rd_valid / rd_ready  read handshake
//   rd_last              (LAST_EN) head byte ends a packet
//   flush                synchronous discard of all contents
//   level[AWIDTH+1]      bytes held, including the output register
//   empty, full          level == 0, level == 2^AWIDTH
module usb_ep_fifo #(
  parameter int WWIDTH    = 32,
  parameter int AWIDTH    = 11,
  parameter     INIT_FILE = ""
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WWIDTH-1:0]   wr_data,
  input  logic [WWIDTH/8-1:0] wr_mask,
  input  logic                wr_valid,
  output logic                wr_ready,
`ifdef USB_EP_FIFO_LAST_EN
  input  logic                wr_last,
  output logic                rd_last,
`endif
  output logic [7:0]          rd_data,
  output logic                rd_valid,
  input  logic                rd_ready,
  input  logic                flush,
  output logic [AWIDTH:0]     level,
  output logic                empty,
  output logic                full
);

  localparam int NB    = WWIDTH / 8;
  localparam int LB    = $clog2(NB);
  localparam int SW    = (LB > 0) ? LB : 1;
  localparam int RW    = AWIDTH - LB;
  localparam int DEPTH = 1 << RW;
  localparam int CAP   = 1 << AWIDTH;
`ifdef USB_EP_FIFO_LAST_EN
  localparam int DW    = 9;
`else
  localparam int DW    = 8;
`endif

  localparam logic [AWIDTH:0] CAP_V = (AWIDTH+1)'(CAP);
  localparam logic [AWIDTH:0] NB_V  = (AWIDTH+1)'(NB);

  logic [AWIDTH:0]   wp, rp, wp_nxt, rp_nxt, lvl, lvl_nxt, nbytes;
  logic [AWIDTH-1:0] raddr;
  logic              accept, rd_hs, re, rd_valid_q, wr_ready_q, ready_nxt;
  logic [SW-1:0]     sel_q, rbank;
  logic [RW-1:0]     rrow;
  logic              we   [NB];
  logic [RW-1:0]     wrow [NB];
  logic [DW-1:0]     wdat [NB];
  logic [DW-1:0]     bank_rd [NB];
  logic [DW-1:0]     rd_sel;

  assign accept = wr_valid & wr_ready_q & ~flush;
  assign rd_hs  = rd_valid_q & rd_ready;
  assign lvl    = wp - rp;

  always_comb begin
    nbytes = '0;
    for (int i = 0; i < NB; i++)
      nbytes = nbytes + (AWIDTH+1)'(wr_mask[i]);
  end

  // Each bank b receives the lane that lands on it: lane = (b - wp) mod NB.
  always_comb begin
    for (int b = 0; b < NB; b++) begin
      int lane;
      int addr;
      lane    = (b - (int'(wp[AWIDTH-1:0]) % NB) + NB) % NB;
      addr    = (int'(wp[AWIDTH-1:0]) + lane) % CAP;
      we[b]   = accept & wr_mask[lane];
      wrow[b] = RW'(addr / NB);
`ifdef USB_EP_FIFO_LAST_EN
      wdat[b] = {wr_last && (lane == int'(nbytes) - 1), wr_data[8*lane +: 8]};
`else
      wdat[b] = wr_data[8*lane +: 8];
`endif
    end
  end

  // The output register holds at most one byte, so the next byte to fetch
  // sits at rp + rd_valid. A fetch is issued whenever the output slot is free
  // (or being drained this cycle) and the banks hold a byte beyond it.
  assign raddr = rp[AWIDTH-1:0] + AWIDTH'(rd_valid_q);
  assign re    = ~flush & (~rd_valid_q | rd_ready) &
                 (lvl > {{AWIDTH{1'b0}}, rd_valid_q});
  assign rrow  = RW'(int'(raddr) / NB);
  assign rbank = SW'(int'(raddr) % NB);

  assign wp_nxt    = flush ? '0 : (accept ? wp + nbytes : wp);
  assign rp_nxt    = flush ? '0 : (rd_hs ? rp + 1'b1 : rp);
  assign lvl_nxt   = wp_nxt - rp_nxt;
  assign ready_nxt = (CAP_V - lvl_nxt) >= NB_V;

  for (genvar b = 0; b < NB; b++) begin : g_bank
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] q;
    always_ff @(posedge clk) begin
      if (we[b]) mem[wrow[b]] <= wdat[b];
      if (re && rbank == SW'(b)) q <= mem[rrow];
    end
    assign bank_rd[b] = q;
  end

  // Bank preload hook: synthesis leaves banks uninitialised; bring-up flows
  // load g_bank[*].mem by hierarchical path when INIT_FILE is set. Pointers
  // still reset to empty either way.
  if (INIT_FILE != "") begin : g_init_hook
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp         <= '0;
      rp         <= '0;
      rd_valid_q <= 1'b0;
      sel_q      <= '0;
      wr_ready_q <= 1'b1;
    end else begin
      wp         <= wp_nxt;
      rp         <= rp_nxt;
      wr_ready_q <= ready_nxt;
      if (flush)      rd_valid_q <= 1'b0;
      else if (re)    rd_valid_q <= 1'b1;
      else if (rd_hs) rd_valid_q <= 1'b0;
      if (re) sel_q <= rbank;
    end
  end

  assign rd_sel   = bank_rd[sel_q];
  assign rd_data  = rd_valid_q ? rd_sel[7:0] : 8'h00;
`ifdef USB_EP_FIFO_LAST_EN
  assign rd_last  = rd_valid_q & rd_sel[8];
`endif
  assign rd_valid = rd_valid_q;
  assign wr_ready = wr_ready_q;
  assign level    = lvl;
  assign empty    = (lvl == '0);
  assign full     = (lvl == CAP_V);

  a_mask_contig: assert property (@(posedge clk) disable iff (!rst_n)
    (wr_valid && wr_ready_q && !flush) |-> ((wr_mask & (wr_mask + NB'(1))) == '0));

endmodule
